// File: rtl/stream_pkg.sv
// Shared types for the two-input stream arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_pkg;

   // Arbiter packet state: no packet open, or a packet open from a / b.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   // Source encoding, shared by f_src and sel.
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // The source that gets priority after a packet from src closes.
   function automatic logic other_src(input logic src);
      return ~src;
   endfunction

endpackage

// File: rtl/stream_arb_2x1_if.sv
// Bundle of the two input streams, the merged output stream and the mux select.
// Latency: n/a (wires only).
// Backpressure: ready from the arbiter to each input, f_ready from the sink into the arbiter.
// Ports: a_*/b_* input streams, f_* merged output stream, sel downstream mux select.
// Modports: slave = arbiter side (consumes a/b, produces f and sel);
//           master = environment side (sources a/b, sinks f).
interface stream_arb_2x1_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_last;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_last;
   logic             b_ready;
   logic             f_valid;
   logic [WIDTH-1:0] f_data;
   logic             f_last;
   logic             f_src;
   logic             f_ready;
   logic             sel;

   modport slave (
      input  a_valid, a_data, a_last,
      input  b_valid, b_data, b_last,
      input  f_ready,
      output a_ready, b_ready,
      output f_valid, f_data, f_last, f_src,
      output sel
   );

   modport master (
      output a_valid, a_data, a_last,
      output b_valid, b_data, b_last,
      output f_ready,
      input  a_ready, b_ready,
      input  f_valid, f_data, f_last, f_src,
      input  sel
   );
endinterface

// File: rtl/rr_grant_2.sv
// Combinational two-way grant: packet lock first, then single requester, then priority.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; the grant is qualified by can_load in the arbiter.
// Ports: i_a_valid/i_b_valid requests, i_prio favoured source, i_state packet state,
//        i_last_sel grant of the previous cycle, o_grant selected source (0 = a, 1 = b).
module rr_grant_2
   import stream_pkg::*;
(
   input  logic   i_a_valid,
   input  logic   i_b_valid,
   input  logic   i_prio,
   input  state_t i_state,
   input  logic   i_last_sel,
   output logic   o_grant
);

   always_comb begin
      o_grant = i_last_sel;
      case (i_state)
         LOCK_A:  o_grant = SRC_A;
         LOCK_B:  o_grant = SRC_B;
         default: begin
            if (i_a_valid && i_b_valid) begin
               o_grant = i_prio;
            end else if (i_a_valid) begin
               o_grant = SRC_A;
            end else if (i_b_valid) begin
               o_grant = SRC_B;
            end
            // No requester: keep the previous select so the mux does not toggle.
         end
      endcase
   end

endmodule

// File: rtl/stream_arb_2x1.sv
// Round-robin 2:1 stream merge with packet lock and a registered output stage.
// Latency: 1 cycle (beat accepted at an edge is on f right after that edge).
// Backpressure: readies drop while the output register is full and f_ready is low.
// Ports: clk, rst (async, active high); bus = slave modport carrying a/b inputs,
//        f output stream and sel (the downstream mux select, equal to the current grant).
module stream_arb_2x1
   import stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   stream_arb_2x1_if.slave       bus
);

   state_t           r_state;
   logic             r_prio;
   logic             r_sel;
   logic             r_f_valid;
   logic [WIDTH-1:0] r_f_data;
   logic             r_f_last;
   logic             r_f_src;

   logic             w_grant;
   logic             w_can_load;
   logic             w_src_valid;
   logic [WIDTH-1:0] w_src_data;
   logic             w_src_last;
   logic             w_accept;

   rr_grant_2 u_grant (
      .i_a_valid  (bus.a_valid),
      .i_b_valid  (bus.b_valid),
      .i_prio     (r_prio),
      .i_state    (r_state),
      .i_last_sel (r_sel),
      .o_grant    (w_grant)
   );

   // The register can take a beat when empty or when its current beat leaves this cycle.
   assign w_can_load  = !r_f_valid || bus.f_ready;

   assign w_src_valid = (w_grant == SRC_B) ? bus.b_valid : bus.a_valid;
   assign w_src_data  = (w_grant == SRC_B) ? bus.b_data  : bus.a_data;
   assign w_src_last  = (w_grant == SRC_B) ? bus.b_last  : bus.a_last;
   assign w_accept    = w_can_load && w_src_valid;

   assign bus.a_ready = w_can_load && (w_grant == SRC_A);
   assign bus.b_ready = w_can_load && (w_grant == SRC_B);
   assign bus.sel     = w_grant;
   assign bus.f_valid = r_f_valid;
   assign bus.f_data  = r_f_data;
   assign bus.f_last  = r_f_last;
   assign bus.f_src   = r_f_src;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_prio    <= SRC_A;
         r_sel     <= SRC_A;
         r_f_valid <= 1'b0;
         r_f_data  <= '0;
         r_f_last  <= 1'b0;
         r_f_src   <= SRC_A;
      end else begin
         r_sel <= w_grant;
         if (w_accept) begin
            r_f_valid <= 1'b1;
            r_f_data  <= w_src_data;
            r_f_last  <= w_src_last;
            r_f_src   <= w_grant;
            if (w_src_last) begin
               // Packet closed: hand priority to the other input.
               r_state <= IDLE;
               r_prio  <= other_src(w_grant);
            end else begin
               r_state <= (w_grant == SRC_B) ? LOCK_B : LOCK_A;
            end
         end else if (bus.f_ready) begin
            r_f_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_arb_2x1.sv
module tb_stream_arb_2x1;
   import stream_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_arb_2x1_if #(.WIDTH(8)) bus ();

   stream_arb_2x1 #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int gcyc  = 0;
   int b_start = 0;

   // Reference model: packet owner, favoured source, previous select, output register image.
   int         m_open;
   logic       m_favour;
   logic       m_last_grant;
   logic       m_fv;
   logic [7:0] m_fd;
   logic       m_fl;
   logic       m_fs;
   logic       m_acc_a;
   logic       m_acc_b;

   logic [8:0] qa[$];
   logic [8:0] qb[$];
   logic [8:0] ra[$];
   logic [8:0] rb[$];
   logic [9:0] outq[$];
   int         outc[$];
   logic [7:0] expq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_open = -1;
      m_favour = 1'b0;
      m_last_grant = 1'b0;
      m_fv = 1'b0;
      m_fd = 8'h00;
      m_fl = 1'b0;
      m_fs = 1'b0;
      m_acc_a = 1'b0;
      m_acc_b = 1'b0;
   endtask

   task automatic do_reset();
      bus.a_valid = 1'b0; bus.a_data = 8'h00; bus.a_last = 1'b0;
      bus.b_valid = 1'b0; bus.b_data = 8'h00; bus.b_last = 1'b0;
      bus.f_ready = 1'b1;
      rst = 1'b1;
      model_reset();
      outq.delete();
      outc.delete();
      #2;
      check("rst_f_valid", bus.f_valid, 1'b0);
      check("rst_f_data",  bus.f_data,  8'h00);
      check("rst_f_last",  bus.f_last,  1'b0);
      check("rst_f_src",   bus.f_src,   1'b0);
      check("rst_sel",     bus.sel,     1'b0);
      check("rst_a_ready", bus.a_ready, 1'b1);
      check("rst_b_ready", bus.b_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock cycle: check combinational outputs against the model, cross the edge,
   // advance the model, then check the registered outputs.
   task automatic tick();
      logic       g;
      logic       cl;
      logic       acc;
      logic       fr;
      logic [8:0] beat;
      #1;
      if (m_open >= 0)                     g = m_open[0];
      else if (bus.a_valid && bus.b_valid) g = m_favour;
      else if (bus.a_valid)                g = 1'b0;
      else if (bus.b_valid)                g = 1'b1;
      else                                 g = m_last_grant;
      fr = bus.f_ready;
      cl = !m_fv || fr;
      check("sel",     bus.sel,     g);
      check("a_ready", bus.a_ready, cl && !g);
      check("b_ready", bus.b_ready, cl && g);
      acc  = cl && (g ? bus.b_valid : bus.a_valid);
      beat = g ? {bus.b_last, bus.b_data} : {bus.a_last, bus.a_data};
      if (bus.f_valid && fr) begin
         outq.push_back({bus.f_src, bus.f_last, bus.f_data});
         outc.push_back(gcyc);
      end
      m_acc_a = acc && !g;
      m_acc_b = acc && g;
      @(posedge clk);
      #1;
      gcyc++;
      m_last_grant = g;
      if (acc) begin
         m_fv = 1'b1;
         m_fd = beat[7:0];
         m_fl = beat[8];
         m_fs = g;
         if (beat[8]) begin
            m_open   = -1;
            m_favour = !g;
         end else begin
            m_open = g ? 1 : 0;
         end
      end else if (fr) begin
         m_fv = 1'b0;
      end
      check("f_valid", bus.f_valid, m_fv);
      if (m_fv) begin
         check("f_data", bus.f_data, m_fd);
         check("f_last", bus.f_last, m_fl);
         check("f_src",  bus.f_src,  m_fs);
      end
   endtask

   // Drive qa/qb until both are sent and the output has drained.
   // rmode 0: valids and f_ready always high; rmode 1: random valid raise and f_ready.
   task automatic run(input int budget, input int rmode);
      int   cyc = 0;
      logic a_on = 1'b0;
      logic b_on = 1'b0;
      while ((qa.size() > 0 || qb.size() > 0 || m_fv) && cyc < budget) begin
         if (qa.size() > 0 && !a_on) a_on = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (qb.size() > 0 && !b_on && cyc >= b_start)
            b_on = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.a_valid = a_on;
         bus.a_data  = a_on ? qa[0][7:0] : 8'h00;
         bus.a_last  = a_on ? qa[0][8]   : 1'b0;
         bus.b_valid = b_on;
         bus.b_data  = b_on ? qb[0][7:0] : 8'h00;
         bus.b_last  = b_on ? qb[0][8]   : 1'b0;
         bus.f_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         if (m_acc_a) begin void'(qa.pop_front()); a_on = 1'b0; end
         if (m_acc_b) begin void'(qb.pop_front()); b_on = 1'b0; end
         cyc++;
      end
      check("run_done", (qa.size() == 0 && qb.size() == 0 && !m_fv), 1'b1);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.f_ready = 1'b1;
   endtask

   // Compare delivered output bytes with expq; optionally require one beat per cycle.
   task automatic check_out(input string tag, input logic gaps);
      check({tag, "_count"}, outq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         check(tag, outq[i][7:0], expq[i]);
         if (gaps && i > 0) check({tag, "_gap"}, outc[i] - outc[i-1], 1);
      end
   endtask

   initial begin
      int ia;
      int ib;
      int open_src;
      int n;

      // Single-source packet
      do_reset();
      qa = {9'h011, 9'h022, 9'h133};
      run(50, 0);
      expq = {8'h11, 8'h22, 8'h33};
      check_out("single", 1'b1);
      check("single_src0", outq[0][9], 1'b0);
      check("single_last_mid", outq[1][8], 1'b0);
      check("single_last_end", outq[2][8], 1'b1);
      check("single_prio", dut.r_prio, 1'b1);

      // Contention right after reset, single-beat packets on both sides
      do_reset();
      qa = {9'h1A0, 9'h1A1};
      qb = {9'h1B0, 9'h1B1};
      run(50, 0);
      expq = {8'hA0, 8'hB0, 8'hA1, 8'hB1};
      check_out("contend", 1'b1);

      // Packet lock: priority moves to b, but an open a packet keeps the grant
      do_reset();
      b_start = 2;
      qa = {9'h101, 9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3};
      qb = {9'h1D0};
      run(50, 0);
      b_start = 0;
      expq = {8'h01, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0};
      check_out("lock", 1'b1);

      // Backpressure with f holding 0x55
      do_reset();
      bus.a_valid = 1'b1; bus.a_data = 8'h55; bus.a_last = 1'b1;
      bus.b_valid = 1'b1; bus.b_data = 8'h66; bus.b_last = 1'b1;
      bus.f_ready = 1'b1;
      tick();
      check("bp_load_a", m_acc_a, 1'b1);
      bus.a_valid = 1'b0;
      bus.f_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_a_ready", bus.a_ready, 1'b0);
         check("bp_b_ready", bus.b_ready, 1'b0);
         tick();
         check("bp_hold", bus.f_data, 8'h55);
      end
      bus.f_ready = 1'b1;
      tick();
      bus.b_valid = 1'b0;
      tick();
      tick();
      expq = {8'h55, 8'h66};
      check_out("bp", 1'b1);

      // Reset in the middle of a b packet
      do_reset();
      bus.b_valid = 1'b1; bus.b_data = 8'hB0; bus.b_last = 1'b0;
      tick();
      bus.b_data = 8'hB1;
      tick();
      check("mid_locked", dut.r_state, LOCK_B);
      bus.b_data = 8'hB2;
      rst = 1'b1;
      #1;
      check("mid_f_valid", bus.f_valid, 1'b0);
      check("mid_state", dut.r_state, IDLE);
      check("mid_prio", dut.r_prio, 1'b0);
      do_reset();
      qa = {9'h1A5};
      qb = {9'h1B5};
      run(50, 0);
      expq = {8'hA5, 8'hB5};
      check_out("mid_after", 1'b1);

      // Randomised traffic against the model, then end-to-end ordering
      do_reset();
      ra.delete();
      rb.delete();
      for (int p = 0; p < 24; p++) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            if (p[0]) rb.push_back({(k == n - 1) ? 1'b1 : 1'b0, 8'($urandom)});
            else      ra.push_back({(k == n - 1) ? 1'b1 : 1'b0, 8'($urandom)});
         end
      end
      qa = ra;
      qb = rb;
      run(3000, 1);
      ia = 0;
      ib = 0;
      open_src = -1;
      foreach (outq[i]) begin
         if (open_src >= 0) check("rnd_atomic", outq[i][9], open_src[0]);
         open_src = outq[i][8] ? -1 : int'(outq[i][9]);
         if (outq[i][9] == 1'b0) begin
            if (ia < ra.size()) check("rnd_a_beat", outq[i][8:0], ra[ia]);
            ia++;
         end else begin
            if (ib < rb.size()) check("rnd_b_beat", outq[i][8:0], rb[ib]);
            ib++;
         end
      end
      check("rnd_a_total", ia, ra.size());
      check("rnd_b_total", ib, rb.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not reach its summary line");
      $fatal(1);
   end

endmodule

// File: doc/stream_arb_2x1.md
# stream_arb_2x1

Two-input round-robin stream arbiter with packet lock. It merges two valid/ready streams, a and b, onto one registered output stream f. It also drives `sel`, which is the select for a downstream 2:1 mux that steers sideband data the same way. It sits directly upstream of the mux and is the block that decides which input the mux passes.

## Interface
- `WIDTH`, default 8: data width of each stream.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `a_valid`, input, 1: stream a beat available.
- `a_data`, input, WIDTH: stream a payload.
- `a_last`, input, 1: final beat of a stream a packet.
- `a_ready`, output, 1: stream a beat accepted this cycle when `a_valid` is also high.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the stream a ports, for stream b.
- `f_valid`, output, 1: output beat held in the register.
- `f_data`, output, WIDTH: output payload.
- `f_last`, output, 1: output beat closes a packet.
- `f_src`, output, 1: source of the output beat (0 = a, 1 = b).
- `f_ready`, input, 1: downstream accepts the output beat.
- `sel`, output, 1: current grant (0 = a, 1 = b); the mux select.

## Operation
- States:
  - IDLE: no packet in progress.
  - LOCK_A: a packet from a is open.
  - LOCK_B: a packet from b is open.
- Priority pointer `prio` (0 = a favoured). Reset value is 0.
- Grant in IDLE:
  - Only one valid: grant it.
  - Both valid: grant `prio`.
  - Neither valid: hold `sel`.
- Grant in LOCK_A / LOCK_B: fixed to that source, whatever the other input does.
- `can_load = !f_valid || f_ready`.
- Ready outputs are combinational:
  - `a_ready = can_load && grant==a`.
  - `b_ready = can_load && grant==b`.
  - The non-granted ready is always 0.
- On accept (granted valid && ready):
  - Load the register with data, last and src.
  - If last = 0: move to LOCK_x.
  - If last = 1: return to IDLE and set `prio` to the other source.
  - A single-beat packet never enters LOCK.
- Output register:
  - If `f_ready` is high with no new accept, `f_valid` drops to 0.
  - If accept and `f_ready` occur together, the register reloads and `f_valid` stays 1.
- `sel` equals the combinational grant and is driven from registered state (`state`, `prio`, last `sel`) plus the input valids.
- Reset values: `f_valid` 0, `f_data` 0, `f_last` 0, `f_src` 0, state IDLE, `prio` 0, `sel` 0.

## Timing
- Latency: a beat accepted at edge N appears on f at edge N (registered), so it is visible in cycle N+1.
- Throughput: one beat per cycle with `f_ready` held high, including back-to-back packets that alternate sources.
- Packet switch: the cycle after the last beat of an a packet is accepted, b may be accepted with no bubble.
- Backpressure:
  - While `f_valid` is high and `f_ready` is low, both readies are 0.
  - f fields hold stable.
- Handshake rules:
  - Inputs must hold valid and data until accepted; no beat is dropped or duplicated.
  - `f_valid` never falls without `f_ready`.
- Reset mid-packet: asserting `rst` returns to IDLE with `prio` 0, discards the register contents, and drops `f_valid` asynchronously.
- Simultaneous arrival in IDLE: the favoured source wins. The loser is not accepted and waits with `ready` 0.

## Structure
- Shared package `stream_pkg`:
  - `state_t` enum: IDLE, LOCK_A, LOCK_B.
  - `SRC_A` = 0, `SRC_B` = 1.
- Sub-module `rr_grant_2`: combinational grant from the two valids, `prio`, state and last `sel`. All other logic (state, `prio`, output register) lives in `stream_arb_2x1`.

## Test plan
- Single source: a sends 3-beat packet 0x11, 0x22, 0x33 (last on 0x33) with `f_ready` = 1, b idle. f shows 0x11, 0x22, 0x33 in consecutive cycles with `f_src` = 0 and `f_last` only on 0x33, and `prio` becomes 1.
- Contention: a and b both valid in IDLE right after reset, each with single-beat packets, a = 0xA0, 0xA1 and b = 0xB0, 0xB1. Output order is 0xA0, 0xB0, 0xA1, 0xB1 with no idle cycles.
- Packet lock: a sends 4 beats while b holds valid throughout. All 4 a beats go out before any b beat, and `b_ready` stays 0 until a's last beat is accepted.
- Backpressure: `f_ready` = 0 for 3 cycles while `f_valid` = 1 holding 0x55. `f_data` stays 0x55, both readies are 0, and 0x55 goes out once when `f_ready` returns to 1.
- Reset mid-packet: assert `rst` after beat 2 of a 4-beat b packet. `f_valid` goes to 0 immediately, state returns to IDLE, and afterwards a is granted first when both are valid.
